spi_slave_tx: RTL and testbench

Synchronous SPI slave transmitter: the responder end of the team's 12-bit SPI link. It accepts a word from the local core via a `newd`/`din` load handshake and shifts it out on `miso`, LSB first, when an external master selects it with `cs` and clocks `sclk` (mode 0). `sclk`, `cs` and `mosi` are oversampled in the `clk` domain. There is no second clock domain inside the block. The block sits beside the existing slave receiver on the peripheral side, so one node can both answer and receive.

---
 rtl/spi_slave_tx.sv | 217 +++++++++++++++++++++
 tb/tb_spi_slave_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx.sv
`default_nettype none
//============================================================================
// Module      : spi_slave_tx
// Description : SPI slave transmitter (mode 0, LSB first). The local core
//               loads a word via newd/din; when the master selects the block
//               with cs and clocks sclk, the word is shifted out on miso.
//               sclk, cs (and mosi when receiving) are oversampled in clk.
// Ports       : clk, rst           - system clock, synchronous active-high reset
//               newd, din, ready   - word load handshake
//               sclk, cs, mosi     - SPI pins from the master (asynchronous)
//               miso               - SPI data out, 0 outside SHIFT
//               done/abort/underrun- single-cycle status pulses
//               dout               - received word (RX build only, else 0)
// Options     : define SPI_SLV_RX_EN for full-duplex operation (mosi capture)
// Revision    : 1.0 - initial release
//============================================================================
module spi_slave_tx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              done,
    output logic              abort,
    output logic              underrun,
    output logic [DATA_W-1:0] dout
);

    localparam int                 c_cnt_w    = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DATA_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detectors. These flops are deliberately
    // not reset: they always track the real pin level, so a reset in the
    // middle of a transfer (cs held low) does not fabricate a cs edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;

    always_ff @(posedge clk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
        r_sclk_d    <= w_sclk_s;
        r_cs_d      <= w_cs_s;
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    // ------------------------------------------------------------------
    // Control FSM and transmit datapath
    // ------------------------------------------------------------------
    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
    logic [c_cnt_w-1:0]  r_bitcnt, w_bitcnt_nxt;
    logic                r_done, w_done_nxt;
    logic                r_abort, w_abort_nxt;
    logic                r_underrun, w_underrun_nxt;
    logic                w_take_rise;

    // An sclk rise counts while selected; the rise that completes the last
    // bit also counts when it coincides with cs rising (done beats abort).
    assign w_take_rise = (r_state == ST_SHIFT) && w_sclk_rise &&
                         (!w_cs_s || (r_bitcnt == c_cnt_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_done     <= w_done_nxt;
            r_abort    <= w_abort_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bitcnt_nxt   = r_bitcnt;
        w_done_nxt     = 1'b0;
        w_abort_nxt    = 1'b0;
        w_underrun_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    // Selected straight from IDLE: a same-cycle load still
                    // makes it; otherwise send zeros and flag the underrun.
                    w_state_nxt  = ST_SHIFT;
                    w_bitcnt_nxt = '0;
                    if (newd) begin
                        w_shreg_nxt = din;
                    end else begin
                        w_shreg_nxt    = '0;
                        w_underrun_nxt = 1'b1;
                    end
                end else if (newd) begin
                    w_shreg_nxt = din;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_cs_fall) begin
                    w_state_nxt  = ST_SHIFT;
                    w_bitcnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (w_take_rise && (r_bitcnt == c_cnt_last)) begin
                    w_bitcnt_nxt = c_cnt_full;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_FINISH;
                end else if (w_cs_rise) begin
                    w_abort_nxt  = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    w_shreg_nxt  = '0;
                    w_bitcnt_nxt = '0;
                end else begin
                    if (w_take_rise && (r_bitcnt != c_cnt_full))
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                    if (w_sclk_fall && !w_cs_s && (r_bitcnt < c_cnt_full))
                        w_shreg_nxt = {1'b0, r_shreg[DATA_W-1:1]};
                end
            end
            ST_FINISH: begin
                if (w_cs_rise) begin
                    w_state_nxt  = ST_IDLE;
                    w_shreg_nxt  = '0;
                    w_bitcnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready    = (r_state == ST_IDLE);
    assign miso     = (r_state == ST_SHIFT) & r_shreg[0];
    assign done     = r_done;
    assign abort    = r_abort;
    assign underrun = r_underrun;

    // ------------------------------------------------------------------
    // Optional receive path
    // ------------------------------------------------------------------
`ifdef SPI_SLV_RX_EN
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi_s;
    logic [DATA_W-1:0]      r_rxreg;
    logic [DATA_W-1:0]      r_dout;
    logic [DATA_W-1:0]      w_rx_shifted;

    always_ff @(posedge clk) begin
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    // mosi has the same synchronizer depth as sclk, so the bit sampled at
    // a detected rise is the one the master set up before its pin rise.
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_shifted = {w_mosi_s, r_rxreg[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxreg <= '0;
            r_dout  <= '0;
        end else begin
            if (w_take_rise)
                r_rxreg <= w_rx_shifted;
            if (w_done_nxt)
                r_dout <= w_rx_shifted;
        end
    end

    assign dout = r_dout;
`else
    logic w_unused_mosi;
    assign w_unused_mosi = mosi;
    assign dout          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx.sv
`default_nettype none
//============================================================================
// Module      : tb_spi_slave_tx
// Description : Self-checking bench for spi_slave_tx. A behavioural mode-0
//               master drives sclk/cs/mosi; expected miso bits are queued
//               when a word is loaded and popped at each master sample.
// Revision    : 1.0 - initial release
//============================================================================
module tb_spi_slave_tx;

    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic          newd;
    logic [DW-1:0] din;
    logic          ready;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic          miso;
    logic          done;
    logic          abort;
    logic          underrun;
    logic [DW-1:0] dout;

    spi_slave_tx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .newd(newd), .din(din), .ready(ready),
        .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .done(done),
        .abort(abort), .underrun(underrun), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_abort  = 0;
    int   n_under  = 0;
    logic sb_bits[$];
    logic [DW-1:0] exp_dout;

    always @(negedge clk) begin
        if (done)     n_done  <= n_done + 1;
        if (abort)    n_abort <= n_abort + 1;
        if (underrun) n_under <= n_under + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) sb_bits.push_back(w[i]);
    endtask

    task automatic load(input logic [DW-1:0] w);
        check("ready_before_load", ready, 1);
        newd = 1'b1;
        din  = w;
        wait_clk(1);
        newd = 1'b0;
        check("ready_after_load", ready, 0);
        push_word(w);
    endtask

    function automatic logic [DW-1:0] rx_expect(input logic [DW-1:0] w);
`ifdef SPI_SLV_RX_EN
        return w;
`else
        return '0;
`endif
    endfunction

    // Mode-0 master, 11-clk half periods. Optionally loads lword in the
    // very cycle the slave detects the cs fall.
    task automatic xfer(input int nbits, input int extra, input logic [DW-1:0] mword,
                        input bit late_load, input logic [DW-1:0] lword,
                        input bit raise_cs, output logic [DW-1:0] got);
        got  = '0;
        mosi = mword[0];
        cs   = 1'b0;
        if (late_load) begin
            wait_clk(2);
            newd = 1'b1;
            din  = lword;
            push_word(lword);
            wait_clk(1);
            newd = 1'b0;
            wait_clk(8);
        end else begin
            wait_clk(11);
        end
        for (int i = 0; i < nbits; i++) begin
            got[i] = miso;
            if (sb_bits.size() == 0) check("sb_empty", 1, 0);
            else check($sformatf("miso_bit%0d", i), miso, sb_bits.pop_front());
            sclk = 1'b1;
            if (i == DW - 1) begin
                wait_clk(2);
                check("done_early", done, 0);
                wait_clk(1);
                check("done_latency", done, 1);
                wait_clk(8);
            end else begin
                wait_clk(11);
            end
            sclk = 1'b0;
            if (i + 1 < DW) mosi = mword[i+1];
            wait_clk(11);
        end
        for (int i = 0; i < extra; i++) begin
            check("miso_after_done", miso, 0);
            sclk = 1'b1;
            wait_clk(11);
            check("miso_after_done_hi", miso, 0);
            sclk = 1'b0;
            wait_clk(11);
        end
        if (raise_cs) begin
            cs = 1'b1;
            wait_clk(3);
            check("ready_after_cs", ready, 1);
            wait_clk(8);
        end
    endtask

    initial begin
        logic [DW-1:0] got;
        int d0, a0, u0;
        rst = 1'b1; newd = 1'b0; din = '0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        exp_dout = '0;
        wait_clk(5);
        check("rst_ready", ready, 1);
        check("rst_miso", miso, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_underrun", underrun, 0);
        check("rst_dout", dout, 0);
        rst = 1'b0;
        wait_clk(5);

        // Basic transfer with extra sclk edges after the last bit
        d0 = n_done;
        load(12'hA5C);
        xfer(DW, 2, 12'h3E1, 1'b0, '0, 1'b1, got);
        check("t1_got", got, 12'hA5C);
        check("t1_done_count", n_done - d0, 1);
        exp_dout = rx_expect(12'h3E1);
        check("t1_dout", dout, exp_dout);

        // Selected with nothing loaded
        d0 = n_done; u0 = n_under;
        for (int i = 0; i < DW; i++) sb_bits.push_back(1'b0);
        xfer(DW, 0, 12'h0F0, 1'b0, '0, 1'b1, got);
        check("t2_underrun", n_under - u0, 1);
        check("t2_done", n_done - d0, 1);
        check("t2_got", got, 12'h000);
        exp_dout = rx_expect(12'h0F0);
        check("t2_dout", dout, exp_dout);

        // Abort after 5 bits, then a clean transfer
        d0 = n_done; a0 = n_abort;
        load(12'hFFF);
        xfer(5, 0, 12'hAAA, 1'b0, '0, 1'b1, got);
        sb_bits.delete();
        check("t3_abort", n_abort - a0, 1);
        check("t3_no_done", n_done - d0, 0);
        check("t3_dout_kept", dout, exp_dout);
        load(12'h001);
        xfer(DW, 0, 12'h9C6, 1'b0, '0, 1'b1, got);
        check("t3_got", got, 12'h001);
        exp_dout = rx_expect(12'h9C6);
        check("t3_dout", dout, exp_dout);

        // Load in the same cycle as the detected cs fall
        u0 = n_under; d0 = n_done;
        xfer(DW, 0, 12'h000, 1'b1, 12'h3C3, 1'b1, got);
        check("t4_got", got, 12'h3C3);
        check("t4_no_underrun", n_under - u0, 0);
        check("t4_done", n_done - d0, 1);

        // Full duplex pattern
        load(12'h123);
        xfer(DW, 0, 12'h5A7, 1'b0, '0, 1'b1, got);
        check("t5_got", got, 12'h123);
        exp_dout = rx_expect(12'h5A7);
        check("t5_dout", dout, exp_dout);

        // Reset in the middle of a transfer
        d0 = n_done; a0 = n_abort; u0 = n_under;
        load(12'h6B5);
        xfer(6, 0, 12'hFFF, 1'b0, '0, 1'b0, got);
        sb_bits.delete();
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("t6_ready", ready, 1);
        check("t6_miso", miso, 0);
        check("t6_dout", dout, 0);
        sclk = 1'b1;
        wait_clk(11);
        check("t6_miso_sclk", miso, 0);
        sclk = 1'b0;
        wait_clk(11);
        cs = 1'b1;
        wait_clk(20);
        check("t6_no_done", n_done - d0, 0);
        check("t6_no_abort", n_abort - a0, 0);
        check("t6_no_underrun", n_under - u0, 0);
        check("t6_ready_end", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
